soc_selftest_monitor: RTL and testbench
=======================================

# soc_selftest_monitor

Parametrised on-chip self-test monitor for the SoC. It scans N_CHK CPU registers through the debug read port (reg_addr/reg_data) and compares each against an expected value. A channel counts as met once its match holds for STABLE_CNT consecutive sampled cycles. The block raises a sticky pass when every channel is met, or fail with the index of the first unmet channel when a TIMEOUT_W-bit timeout expires.

## Interface
Parameters:
- DATA_W, 32: debug register data width
- ADDR_W, 5: debug register address width
- N_CHK, 2: number of check channels (≥1)
- TIMEOUT_W, 8: timeout counter width; scan window is 2^TIMEOUT_W cycles
- STABLE_CNT, 2: consecutive matching samples required per channel (≥1)
- IDX_W, max(1,$clog2(N_CHK)): channel index width (derived, localparam)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  one clock; reset is asynchronous and active-low
- enable  in  1  start/hold; low returns the block to IDLE
- chk_addr  in  N_CHK*ADDR_W  packed register addresses; channel i in bits [i*ADDR_W +: ADDR_W]
- chk_value  in  N_CHK*DATA_W  packed expected values, same packing
- reg_addr  out  ADDR_W  debug read address = chk_addr slice [idx]
- reg_data  in  DATA_W  debug read data; combinational response to reg_addr
- busy  out  1  high in SCAN
- pass  out  1  sticky pass
- fail  out  1  sticky fail
- fail_idx  out  IDX_W  lowest unmet channel at timeout; 0 otherwise
- met  out  N_CHK  per-channel met mask

## Operation
- State machine: IDLE, SCAN, PASS, FAIL.
- IDLE: busy=0, pass=0, fail=0. idx, stable, timer, met and fail_idx are cleared.
  - enable=1 → SCAN on the next edge.
- SCAN: sample reg_data for channel idx in each cycle.
  - Match (reg_data == chk_value[idx]) with stable == STABLE_CNT-1: set met[idx], clear stable, move idx to the next unmet channel (round-robin, wrapping N_CHK-1→0).
  - Match with stable < STABLE_CNT-1: stable+1, idx unchanged.
  - Mismatch: clear stable, move idx to the next unmet channel.
    - If channel idx is the only unmet channel, idx stays and only stable clears.
  - The timer increments every SCAN cycle.
- SCAN exits:
  - Completing met → all ones: go to PASS.
  - Otherwise, timer at all ones: go to FAIL and latch fail_idx = lowest unmet channel.
  - Both in the same cycle: PASS wins.
- PASS/FAIL: outputs held while enable=1. idx frozen; met frozen.
- enable=0 in any state: return to IDLE on the next edge and clear all state. This includes aborting SCAN mid-check.
- Met channels are never rechecked; a later mismatch does not clear met.
- N_CHK=1: idx is constant 0.
- STABLE_CNT=1: a single matching sample sets met.

## Timing
- Reset (async, rst_n low): state=IDLE, busy=0, pass=0, fail=0, fail_idx=0, met=0, idx=0, stable=0, timer=0.
- reg_addr is combinational from registered idx, so reg_addr is valid the whole cycle. reg_data is compared in the same cycle.
- busy rises on the edge after enable is sampled high in IDLE.
- pass and fail are registered. They assert on the edge that ends the deciding SCAN cycle.
- Minimum pass latency after entering SCAN: N_CHK*STABLE_CNT cycles.
- Maximum SCAN duration: 2^TIMEOUT_W cycles. fail rises on the edge ending SCAN cycle number 2^TIMEOUT_W, counting from 1.
- pass and fail are mutually exclusive and never both 1.

## Test plan
1. **Pass with default channels.** Defaults: ch0 addr 10 = 32'h00213d05, ch1 addr 11 = 0. Model returns both values constantly; enable=1 → pass=1 after 4 SCAN cycles, met=2'b11, fail=0, busy=0.
2. **Stable-count reset and round-robin.** Same setup, but ch0 matches only on alternating cycles (glitchy) → met[0] never sets while glitching. Mid-glitch, the scan rotates to ch1 (ch1 matches) → met=2'b10.
3. **Timeout.** TIMEOUT_W=4; ch1 never matches → fail rises exactly 16 cycles after SCAN entry, fail_idx=1, pass=0.
4. **Simultaneous completion and timeout.** Final match lands on timer=all ones → pass=1, fail=0.
5. **Abort by enable.** Drop enable mid-SCAN after met=2'b01 → IDLE next edge, met=0, busy=0. Re-enable → full rescan.
6. **Async reset in PASS.** Assert rst_n=0 asynchronously between edges while in PASS → pass, met and busy clear immediately, without waiting for clk.

Source files
------------

// File: rtl/soc_selftest_monitor.sv
`default_nettype none
// ============================================================================
// Module   : soc_selftest_monitor
// Purpose  : On-chip self-test monitor. Scans N_CHK CPU registers through the
//            debug read port and compares each against an expected value. A
//            channel is met after STABLE_CNT consecutive matching samples.
//            A sticky pass is raised when every channel is met, or a sticky
//            fail (with the lowest unmet channel index) when the scan window
//            of 2^TIMEOUT_W cycles expires.
// Ports    : clk       - clock, all state on rising edge
//            rst_n     - asynchronous active-low reset
//            enable    - start/hold; low returns the block to IDLE
//            chk_addr  - packed per-channel register addresses
//            chk_value - packed per-channel expected values
//            reg_addr  - debug read address for the channel being sampled
//            reg_data  - debug read data (combinational from reg_addr)
//            busy      - high while scanning
//            pass      - sticky pass
//            fail      - sticky fail
//            fail_idx  - lowest unmet channel at timeout, 0 otherwise
//            met       - per-channel met mask
// Revision : 1.0 - initial release
// ============================================================================
module soc_selftest_monitor #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int N_CHK      = 2,
    parameter int TIMEOUT_W  = 8,
    parameter int STABLE_CNT = 2,
    localparam int IDX_W     = (N_CHK > 1) ? $clog2(N_CHK) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [N_CHK*ADDR_W-1:0] chk_addr,
    input  logic [N_CHK*DATA_W-1:0] chk_value,
    output logic [ADDR_W-1:0]       reg_addr,
    input  logic [DATA_W-1:0]       reg_data,
    output logic                    busy,
    output logic                    pass,
    output logic                    fail,
    output logic [IDX_W-1:0]        fail_idx,
    output logic [N_CHK-1:0]        met
);

    localparam int c_STB_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_PASS = 2'd2;
    localparam logic [1:0] S_FAIL = 2'd3;

    logic [1:0]           r_state,    w_state_nxt;
    logic [IDX_W-1:0]     r_idx,      w_idx_nxt;
    logic [c_STB_W-1:0]   r_stable,   w_stable_nxt;
    logic [TIMEOUT_W-1:0] r_timer,    w_timer_nxt;
    logic [N_CHK-1:0]     r_met,      w_met_nxt;
    logic [IDX_W-1:0]     r_fail_idx, w_fail_idx_nxt;

    logic [DATA_W-1:0]    w_exp;
    logic                 w_match;
    logic                 w_last_sample;
    logic [N_CHK-1:0]     w_met_upd;
    logic [N_CHK-1:0]     w_skip_mask;
    logic [IDX_W-1:0]     w_rr_idx;
    logic                 w_rr_found;
    logic [IDX_W-1:0]     w_lowest_unmet;

    assign reg_addr      = chk_addr[r_idx*ADDR_W +: ADDR_W];
    assign w_exp         = chk_value[r_idx*DATA_W +: DATA_W];
    assign w_match       = (reg_data == w_exp);
    assign w_last_sample = (r_stable == c_STB_W'(STABLE_CNT - 1));

    // Met mask as it will be after this cycle if the current sample completes
    // the channel.
    assign w_met_upd   = (w_match && w_last_sample) ? (r_met | (N_CHK'(1) << r_idx)) : r_met;
    // Channels to skip when rotating. On a mismatch the current channel is
    // still unmet, so it is found last (offset N_CHK) and idx stays put when
    // it is the only unmet channel.
    assign w_skip_mask = w_met_upd;

    // Round-robin search for the next unmet channel after r_idx.
    always_comb begin
        int j;
        j          = 0;
        w_rr_idx   = r_idx;
        w_rr_found = 1'b0;
        for (int k = 1; k <= N_CHK; k++) begin
            j = int'(r_idx) + k;
            if (j >= N_CHK) j = j - N_CHK;
            if (!w_rr_found && !w_skip_mask[IDX_W'(j)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = IDX_W'(j);
            end
        end
    end

    // Lowest unmet channel, reported on timeout.
    always_comb begin
        w_lowest_unmet = '0;
        for (int i = N_CHK - 1; i >= 0; i--) begin
            if (!w_met_upd[i]) w_lowest_unmet = IDX_W'(i);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_stable_nxt   = r_stable;
        w_timer_nxt    = r_timer;
        w_met_nxt      = r_met;
        w_fail_idx_nxt = r_fail_idx;

        if (!enable) begin
            w_state_nxt    = S_IDLE;
            w_idx_nxt      = '0;
            w_stable_nxt   = '0;
            w_timer_nxt    = '0;
            w_met_nxt      = '0;
            w_fail_idx_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_SCAN;
                end
                S_SCAN: begin
                    w_timer_nxt = r_timer + 1'b1;
                    w_met_nxt   = w_met_upd;
                    if (w_match && !w_last_sample) begin
                        w_stable_nxt = r_stable + 1'b1;
                    end else begin
                        w_stable_nxt = '0;
                        w_idx_nxt    = w_rr_idx;
                    end
                    // Completion takes priority over a coincident timeout.
                    if (&w_met_upd) begin
                        w_state_nxt = S_PASS;
                        w_idx_nxt   = r_idx;
                    end else if (&r_timer) begin
                        w_state_nxt    = S_FAIL;
                        w_fail_idx_nxt = w_lowest_unmet;
                        w_idx_nxt      = r_idx;
                    end
                end
                default: begin
                    // PASS/FAIL hold everything until enable drops.
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_stable   <= '0;
            r_timer    <= '0;
            r_met      <= '0;
            r_fail_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_stable   <= w_stable_nxt;
            r_timer    <= w_timer_nxt;
            r_met      <= w_met_nxt;
            r_fail_idx <= w_fail_idx_nxt;
        end
    end

    assign busy     = (r_state == S_SCAN);
    assign pass     = (r_state == S_PASS);
    assign fail     = (r_state == S_FAIL);
    assign fail_idx = r_fail_idx;
    assign met      = r_met;

endmodule
`default_nettype wire

// File: tb/tb_soc_selftest_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_soc_selftest_monitor
// Purpose  : Directed self-checking bench for soc_selftest_monitor. Two
//            instances: default parameters, and TIMEOUT_W=4 for the timeout
//            scenarios. A small register model answers the debug port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_soc_selftest_monitor;

    localparam logic [31:0] c_CH0_VAL = 32'h00213d05;
    localparam logic [31:0] c_CH1_VAL = 32'h00000000;
    localparam logic [31:0] c_BAD_VAL = 32'hdeadbeef;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;

    // default-parameter instance
    logic        en_a;
    logic        a_ch0_ok, a_ch1_ok;
    logic [4:0]  a_reg_addr;
    logic [31:0] a_reg_data;
    logic        a_busy, a_pass, a_fail;
    logic [0:0]  a_fail_idx;
    logic [1:0]  a_met;

    // short-timeout instance
    logic        en_b;
    logic        b_ch0_ok, b_ch1_ok;
    logic [4:0]  b_reg_addr;
    logic [31:0] b_reg_data;
    logic        b_busy, b_pass, b_fail;
    logic [0:0]  b_fail_idx;
    logic [1:0]  b_met;

    logic [9:0]  chk_addr;
    logic [63:0] chk_value;

    assign chk_addr  = {5'd11, 5'd10};
    assign chk_value = {c_CH1_VAL, c_CH0_VAL};

    assign a_reg_data = (a_reg_addr == 5'd10 && a_ch0_ok) ? c_CH0_VAL :
                        (a_reg_addr == 5'd11 && a_ch1_ok) ? c_CH1_VAL : c_BAD_VAL;
    assign b_reg_data = (b_reg_addr == 5'd10 && b_ch0_ok) ? c_CH0_VAL :
                        (b_reg_addr == 5'd11 && b_ch1_ok) ? c_CH1_VAL : c_BAD_VAL;

    soc_selftest_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a),
        .chk_addr(chk_addr), .chk_value(chk_value),
        .reg_addr(a_reg_addr), .reg_data(a_reg_data),
        .busy(a_busy), .pass(a_pass), .fail(a_fail),
        .fail_idx(a_fail_idx), .met(a_met)
    );

    soc_selftest_monitor #(.TIMEOUT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b),
        .chk_addr(chk_addr), .chk_value(chk_value),
        .reg_addr(b_reg_addr), .reg_data(b_reg_data),
        .busy(b_busy), .pass(b_pass), .fail(b_fail),
        .fail_idx(b_fail_idx), .met(b_met)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        if ({a_busy, a_pass, a_fail} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {a_busy, a_pass, a_fail});
        end
        checks++;
        if (a_met !== 2'b00 || a_fail_idx !== 1'b0) begin
            errors++; $display("FAIL reset_met got met=%b idx=%b want 00/0", a_met, a_fail_idx);
        end
        checks++;
        if (a_reg_addr !== 5'd10) begin
            errors++; $display("FAIL reset_addr got %0d want 10", a_reg_addr);
        end
        checks++;
    endtask

    task automatic test_pass;
        a_ch0_ok = 1'b1; a_ch1_ok = 1'b1; en_a = 1'b1;
        tick(1);
        if (a_busy !== 1'b1 || a_met !== 2'b00) begin
            errors++; $display("FAIL pass_enter got busy=%b met=%b want 1/00", a_busy, a_met);
        end
        checks++;
        tick(3);
        if (a_pass !== 1'b0 || a_busy !== 1'b1 || a_met !== 2'b01) begin
            errors++; $display("FAIL pass_early got pass=%b busy=%b met=%b want 0/1/01", a_pass, a_busy, a_met);
        end
        checks++;
        tick(1);
        if ({a_pass, a_fail, a_busy} !== 3'b100 || a_met !== 2'b11) begin
            errors++; $display("FAIL pass_done got pfb=%b met=%b want 100/11", {a_pass, a_fail, a_busy}, a_met);
        end
        checks++;
        tick(2);
        if (a_pass !== 1'b1 || a_met !== 2'b11) begin
            errors++; $display("FAIL pass_sticky got pass=%b met=%b want 1/11", a_pass, a_met);
        end
        checks++;
    endtask

    task automatic test_glitch;
        en_a = 1'b0;
        tick(1);
        if (a_pass !== 1'b0 || a_met !== 2'b00) begin
            errors++; $display("FAIL glitch_idle got pass=%b met=%b want 0/00", a_pass, a_met);
        end
        checks++;
        a_ch1_ok = 1'b1; en_a = 1'b1;
        tick(1);
        for (int i = 0; i < 10; i++) begin
            a_ch0_ok = i[0];
            tick(1);
            if (a_met[0] !== 1'b0) begin
                errors++; $display("FAIL glitch_met0 cycle %0d got %b want 0", i, a_met[0]);
            end
            checks++;
        end
        if (a_met !== 2'b10 || a_busy !== 1'b1) begin
            errors++; $display("FAIL glitch_rr got met=%b busy=%b want 10/1", a_met, a_busy);
        end
        checks++;
        a_ch0_ok = 1'b1;
        tick(2);
        if (a_pass !== 1'b1 || a_met !== 2'b11) begin
            errors++; $display("FAIL glitch_recover got pass=%b met=%b want 1/11", a_pass, a_met);
        end
        checks++;
    endtask

    task automatic test_timeout;
        b_ch0_ok = 1'b1; b_ch1_ok = 1'b0; en_b = 1'b1;
        tick(1);
        tick(15);
        if (b_fail !== 1'b0 || b_busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early got fail=%b busy=%b want 0/1", b_fail, b_busy);
        end
        checks++;
        tick(1);
        if ({b_pass, b_fail, b_busy} !== 3'b010 || b_fail_idx !== 1'b1 || b_met !== 2'b01) begin
            errors++; $display("FAIL timeout_fire got pfb=%b idx=%b met=%b want 010/1/01",
                               {b_pass, b_fail, b_busy}, b_fail_idx, b_met);
        end
        checks++;
        tick(2);
        if (b_fail !== 1'b1 || b_pass !== 1'b0) begin
            errors++; $display("FAIL timeout_sticky got fail=%b pass=%b want 1/0", b_fail, b_pass);
        end
        checks++;
    endtask

    task automatic test_simultaneous;
        en_b = 1'b0;
        tick(1);
        if (b_fail !== 1'b0 || b_fail_idx !== 1'b0) begin
            errors++; $display("FAIL simul_idle got fail=%b idx=%b want 0/0", b_fail, b_fail_idx);
        end
        checks++;
        b_ch0_ok = 1'b1; b_ch1_ok = 1'b0; en_b = 1'b1;
        tick(1);
        tick(14);
        b_ch1_ok = 1'b1;
        tick(1);
        if ({b_pass, b_fail, b_busy} !== 3'b001) begin
            errors++; $display("FAIL simul_pre got pfb=%b want 001", {b_pass, b_fail, b_busy});
        end
        checks++;
        tick(1);
        if ({b_pass, b_fail, b_busy} !== 3'b100 || b_met !== 2'b11) begin
            errors++; $display("FAIL simul_win got pfb=%b met=%b want 100/11", {b_pass, b_fail, b_busy}, b_met);
        end
        checks++;
    endtask

    task automatic test_abort;
        en_a = 1'b0;
        tick(1);
        a_ch0_ok = 1'b1; a_ch1_ok = 1'b0; en_a = 1'b1;
        tick(1);
        tick(3);
        if (a_met !== 2'b01 || a_busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre got met=%b busy=%b want 01/1", a_met, a_busy);
        end
        checks++;
        en_a = 1'b0;
        tick(1);
        if (a_met !== 2'b00 || a_busy !== 1'b0 || a_pass !== 1'b0 || a_reg_addr !== 5'd10) begin
            errors++; $display("FAIL abort_idle got met=%b busy=%b pass=%b addr=%0d want 00/0/0/10",
                               a_met, a_busy, a_pass, a_reg_addr);
        end
        checks++;
        a_ch1_ok = 1'b1; en_a = 1'b1;
        tick(1);
        tick(3);
        if (a_pass !== 1'b0 || a_met !== 2'b01) begin
            errors++; $display("FAIL abort_rescan got pass=%b met=%b want 0/01", a_pass, a_met);
        end
        checks++;
        tick(1);
        if (a_pass !== 1'b1) begin
            errors++; $display("FAIL abort_pass got pass=%b want 1", a_pass);
        end
        checks++;
    endtask

    task automatic test_async_reset;
        #2;
        rst_n = 1'b0;
        #1;
        if ({a_pass, a_busy, a_fail} !== 3'b000 || a_met !== 2'b00) begin
            errors++; $display("FAIL async_rst got pbf=%b met=%b want 000/00", {a_pass, a_busy, a_fail}, a_met);
        end
        checks++;
        if (b_pass !== 1'b0 || b_met !== 2'b00) begin
            errors++; $display("FAIL async_rst_b got pass=%b met=%b want 0/00", b_pass, b_met);
        end
        checks++;
        en_a = 1'b0; en_b = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(1);
        if (a_pass !== 1'b0 || a_busy !== 1'b0) begin
            errors++; $display("FAIL async_rel got pass=%b busy=%b want 0/0", a_pass, a_busy);
        end
        checks++;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        a_ch0_ok = 1'b0; a_ch1_ok = 1'b0;
        b_ch0_ok = 1'b0; b_ch1_ok = 1'b0;
        tick(2);
        test_reset();
        rst_n = 1'b1;
        tick(1);
        test_pass();
        test_glitch();
        test_timeout();
        test_simultaneous();
        test_abort();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
